memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of addresses and data.
REQ-002 Parameter MEMORY_DEPTH, default 64: words per region, for both text and data.
REQ-003 Parameter MAX_LS_STREAK, default 2: consecutive LS grants allowed while IF waits.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 if_req  in  1  instruction-fetch request; held until if_ready.
REQ-007 if_addr  in  32  fetch byte address.
REQ-008 if_ready  out  1  one-cycle completion pulse for IF.
REQ-009 if_rdata  out  32  fetched word, valid while if_ready=1.
REQ-010 if_fault  out  1  IF access rejected, valid while if_ready=1.
REQ-011 ls_req  in  1  load/store request; held until ls_ready.
REQ-012 ls_we  in  1  1 = store, 0 = load.
REQ-013 ls_addr  in  32  load/store byte address.
REQ-014 ls_wdata  in  32  store data.
REQ-015 ls_ready  out  1  one-cycle completion pulse for LS.
REQ-016 ls_rdata  out  32  load data, valid while ls_ready=1.
REQ-017 ls_fault  out  1  LS access rejected, valid while ls_ready=1.
REQ-018 mem_enable  out  1  write enable to the shared memory system.
REQ-019 mem_addr  out  32  byte address to the shared memory system.
REQ-020 mem_wdata  out  32  write data to the shared memory system.
REQ-021 mem_rdata  in  32  combinational read data from the shared memory system.

Function
REQ-022 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-023 In IDLE or DONE with any req high, the arbiter SHALL grant one requester, latch its address, we and wdata, and go to ACCESS; with no req it SHALL go to IDLE.
REQ-024 Arbitration SHALL favour LS over IF, except IF SHALL be granted when if_req=1 and the LS streak counter equals MAX_LS_STREAK.
REQ-025 The streak counter SHALL increment on each LS grant while if_req=1, SHALL clear on an IF grant, and SHALL saturate at MAX_LS_STREAK.
REQ-026 A requester whose ready pulses in DONE SHALL NOT be re-granted in that same DONE cycle.
REQ-027 In ACCESS, mem_addr and mem_wdata SHALL present the latched values, stable for the whole cycle.
REQ-028 mem_enable SHALL be 1 only in ACCESS for a legal store, and 0 at all other times.
REQ-029 At the ACCESS-to-DONE edge, mem_rdata SHALL be captured into the granted port's rdata register.
REQ-030 In DONE, exactly the granted port's ready SHALL be 1 for one cycle.
REQ-031 The other port's ready, rdata and fault SHALL be 0 in DONE.
REQ-032 Latency SHALL be 2 cycles from grant to the ready pulse; back-to-back throughput SHALL be one access per 2 cycles.
REQ-033 A legal text address SHALL be 0x00400000 to 0x00400000+4*MEMORY_DEPTH-1 (0x004000FF at the default depth).
REQ-034 A legal data address SHALL be 0x10010000 to 0x10010000+4*MEMORY_DEPTH-1.
REQ-035 IF SHALL be legal only for a text address; loads SHALL be legal for a text or data address; stores SHALL be legal only for a data address.
REQ-036 Any address with addr[1:0]!=0 SHALL be illegal.
REQ-037 An illegal access SHALL still pass through ACCESS and DONE, with mem_enable=0, rdata=0 and fault=1 on the ready cycle.
REQ-038 A req that drops before its grant SHALL be ignored.
REQ-039 Once granted, an access SHALL complete regardless of req.
REQ-040 rdata and fault SHALL be 0 whenever the corresponding ready is 0.

Reset
REQ-041 Asserting reset SHALL immediately force IDLE and clear the streak counter, with no clock edge required.
REQ-042 Asserting reset SHALL immediately drive all outputs to 0, including mem_enable, mem_addr and mem_wdata.
REQ-043 An access in flight during reset SHALL be dropped; no ready pulse and no memory write SHALL occur for it.
REQ-044 The first grant SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-045 IF-only: if_req=1, if_addr=0x00400004 with memory word1=0x20080005 -> if_ready on cycle 2 after grant, if_rdata=0x20080005, if_fault=0.
REQ-046 Store then load: store 0xDEADBEEF to 0x10010008 -> mem_enable=1 for one ACCESS cycle; then load from 0x10010008 -> ls_rdata=0xDEADBEEF.
REQ-047 Simultaneous requests: if_req and ls_req both held -> grant order LS, LS, IF, LS, LS, IF; streak counter clears on each IF grant.
REQ-048 Faults: store to 0x00400000, load from 0x10010002, and IF from 0x10010000 -> each gives ready with fault=1 and rdata=0; mem_enable is never 1.
REQ-049 Reset mid-store: assert reset during ACCESS of a store to 0x10010010 -> mem_enable falls to 0 immediately, no ls_ready, and the old word at 0x10010010 is preserved.
REQ-050 Out of range: load from 0x10010100 at the default depth -> ls_fault=1.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of a single shared memory.
// Every access takes IDLE/DONE -> ACCESS -> DONE; illegal accesses still complete, with a fault.
module memory_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int MEMORY_DEPTH  = 64,
   parameter int MAX_LS_STREAK = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [DATA_WIDTH-1:0] if_addr,
   output logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_fault,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic [DATA_WIDTH-1:0] ls_addr,
   input  logic [DATA_WIDTH-1:0] ls_wdata,
   output logic                  ls_ready,
   output logic [DATA_WIDTH-1:0] ls_rdata,
   output logic                  ls_fault,
   output logic                  mem_enable,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam int SW = $clog2(MAX_LS_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

   localparam logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(32'h0040_0000);
   localparam logic [DATA_WIDTH-1:0] DATA_BASE    = DATA_WIDTH'(32'h1001_0000);
   localparam logic [DATA_WIDTH-1:0] REGION_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

   logic [1:0]            state_q, state_d;
   logic                  gnt_ls_q, gnt_ls_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  legal_q, legal_d;
   logic [SW-1:0]         streak_q, streak_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  fault_q, fault_d;

   logic                  if_win, ls_win;
   logic [DATA_WIDTH-1:0] sel_addr;
   logic                  in_text, in_data, sel_legal;

   always_comb begin
      if_win = 1'b0;
      ls_win = 1'b0;
      if (if_req && (streak_q == STREAK_MAX || !ls_req)) if_win = 1'b1;
      else if (ls_req) ls_win = 1'b1;
      // If the arbitration winner is the port being answered this DONE cycle, its req
      // is still the old one: skip a cycle instead of handing the slot to the loser,
      // so the streak limit (not the ready timing) decides the interleave.
      if (state_q == S_DONE && ((ls_win && gnt_ls_q) || (if_win && !gnt_ls_q))) begin
         if_win = 1'b0;
         ls_win = 1'b0;
      end

      sel_addr  = ls_win ? ls_addr : if_addr;
      // Unsigned offset compare also rejects addresses below the base (wraps large).
      in_text   = (sel_addr - TEXT_BASE) < REGION_BYTES;
      in_data   = (sel_addr - DATA_BASE) < REGION_BYTES;
      sel_legal = (sel_addr[1:0] == 2'b00) &&
                  (if_win ? in_text : (ls_we ? in_data : (in_text || in_data)));

      state_d  = state_q;
      gnt_ls_d = gnt_ls_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      legal_d  = legal_q;
      streak_d = streak_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (if_win || ls_win) begin
               state_d  = S_ACCESS;
               gnt_ls_d = ls_win;
               addr_d   = sel_addr;
               we_d     = ls_win && ls_we;
               wdata_d  = ls_win ? ls_wdata : '0;
               legal_d  = sel_legal;
               if (if_win) streak_d = '0;
               else if (if_req && streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCESS: begin
            state_d = S_DONE;
            rdata_d = legal_q ? mem_rdata : '0;
            fault_d = !legal_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         gnt_ls_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         legal_q  <= 1'b0;
         streak_q <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_ls_q <= gnt_ls_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         legal_q  <= legal_d;
         streak_q <= streak_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   assign if_ready   = (state_q == S_DONE) && !gnt_ls_q;
   assign ls_ready   = (state_q == S_DONE) && gnt_ls_q;
   assign if_rdata   = if_ready ? rdata_q : '0;
   assign ls_rdata   = ls_ready ? rdata_q : '0;
   assign if_fault   = if_ready && fault_q;
   assign ls_fault   = ls_ready && fault_q;
   assign mem_enable = (state_q == S_ACCESS) && we_q && legal_q;
   assign mem_addr   = (state_q == S_ACCESS) ? addr_q  : '0;
   assign mem_wdata  = (state_q == S_ACCESS) ? wdata_q : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random LS/IF traffic checked against
// a transaction-level model (address rules, shadow memory, streak-based grant order).
module tb_memory_arbiter;

   localparam logic [31:0] TEXT  = 32'h0040_0000;
   localparam logic [31:0] DATA  = 32'h1001_0000;
   localparam int          DEPTH = 64;
   localparam int          MAXS  = 2;

   logic        clk = 1'b0, reset = 1'b0;
   logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
   logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
   logic        if_ready, if_fault, ls_ready, ls_fault, mem_enable;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] tmem [0:DEPTH-1];
   logic [31:0] dmem [0:DEPTH-1];
   logic [31:0] seed_d [0:DEPTH-1];
   logic [31:0] ref_t [0:DEPTH-1];
   logic [31:0] ref_d [0:DEPTH-1];
   logic        mem_init = 1'b1;
   int          en_cnt = 0;
   int          checks = 0, errors = 0;

   memory_arbiter #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .MAX_LS_STREAK(MAXS)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_fault(if_fault),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ready(ls_ready), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
      .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Shared memory device: combinational read, write on the clock edge.
   always_comb begin
      mem_rdata = '0;
      if (mem_addr[31:8] == TEXT[31:8]) mem_rdata = tmem[mem_addr[7:2]];
      else if (mem_addr[31:8] == DATA[31:8]) mem_rdata = dmem[mem_addr[7:2]];
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < DEPTH; i++) dmem[i] <= seed_d[i];
      end else if (mem_enable && mem_addr[31:8] == DATA[31:8]) begin
         dmem[mem_addr[7:2]] <= mem_wdata;
      end
   end

   always @(negedge clk) if (mem_enable) en_cnt <= en_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // kind: 0 = fetch, 1 = load, 2 = store
   function automatic logic legal(input int kind, input logic [31:0] a);
      logic t, d;
      t = (a >= TEXT) && (a <= TEXT + 4 * DEPTH - 1);
      d = (a >= DATA) && (a <= DATA + 4 * DEPTH - 1);
      if (a % 4 != 0) return 1'b0;
      case (kind)
         0:       return t;
         1:       return t || d;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (a >= TEXT && a < TEXT + 4 * DEPTH) return ref_t[(a - TEXT) / 4];
      return ref_d[(a - DATA) / 4];
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 5))
         0:       return TEXT + 4 * $urandom_range(0, DEPTH - 1);
         1, 2:    return DATA + 4 * $urandom_range(0, DEPTH - 1);
         3:       return DATA + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
         4:       return DATA + 4 * DEPTH + 4 * $urandom_range(0, 15);
         default: return TEXT - 4 * $urandom_range(1, 4);
      endcase
   endfunction

   task automatic ls_op(input logic we, input logic [31:0] a, input logic [31:0] wd);
      int n, en0;
      logic lg;
      lg  = legal(we ? 2 : 1, a);
      en0 = en_cnt;
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
         if (n == 1) begin
            chk("ls_access_addr", mem_addr, a);
            chk("ls_access_en", {31'b0, mem_enable}, {31'b0, we && lg});
            chk("ls_rdata_not_ready", ls_rdata, 32'h0);
         end
      end while (!ls_ready && n < 10);
      chk("ls_ready", {31'b0, ls_ready}, 32'h1);
      chk("ls_latency", n, 2);
      chk("ls_fault", {31'b0, ls_fault}, {31'b0, !lg});
      if (!we || !lg) chk("ls_rdata", ls_rdata, (lg && !we) ? ref_read(a) : 32'h0);
      chk("if_quiet", {if_ready, if_fault, if_rdata[29:0]}, 32'h0);
      ls_req = 1'b0;
      chk("ls_en_count", en_cnt - en0, (we && lg) ? 1 : 0);
      if (we && lg) ref_d[(a - DATA) / 4] = wd;
   endtask

   task automatic if_op(input logic [31:0] a);
      int n;
      logic lg;
      lg = legal(0, a);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = a;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!if_ready && n < 10);
      chk("if_ready", {31'b0, if_ready}, 32'h1);
      chk("if_latency", n, 2);
      chk("if_fault", {31'b0, if_fault}, {31'b0, !lg});
      chk("if_rdata", if_rdata, lg ? ref_read(a) : 32'h0);
      chk("ls_quiet", {ls_ready, ls_fault, ls_rdata[29:0]}, 32'h0);
      if_req = 1'b0;
   endtask

   initial begin
      int en0, got, cyc, seen, streak;
      logic [31:0] old, wd;
      string exp_seq, got_seq;

      for (int i = 0; i < DEPTH; i++) begin
         tmem[i]   = $urandom;
         seed_d[i] = $urandom;
         ref_d[i]  = seed_d[i];
      end
      tmem[1] = 32'h2008_0005;
      for (int i = 0; i < DEPTH; i++) ref_t[i] = tmem[i];

      #2 reset = 1'b1;
      #1;
      chk("rst_outputs", {if_ready, if_fault, ls_ready, ls_fault, mem_enable, 27'b0}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_rdata", if_rdata | ls_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0; mem_init = 1'b0;

      // Fetch, store/load round trip, faults, out-of-range
      if_op(TEXT + 32'h4);
      en0 = en_cnt;
      ls_op(1'b1, DATA + 32'h8, 32'hDEAD_BEEF);
      ls_op(1'b0, DATA + 32'h8, 32'h0);
      chk("store_load_word", ref_d[2], 32'hDEAD_BEEF);
      chk("store_enable_cycles", en_cnt - en0, 1);
      en0 = en_cnt;
      ls_op(1'b1, TEXT, 32'h1234_5678);
      ls_op(1'b0, DATA + 32'h2, 32'h0);
      if_op(DATA);
      ls_op(1'b0, DATA + 32'h100, 32'h0);
      chk("fault_no_enable", en_cnt - en0, 0);

      // Random traffic
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) if_op(rand_addr());
         else ls_op($urandom_range(0, 1) == 1, rand_addr(), $urandom);
      end
      for (int i = 0; i < DEPTH; i++) chk("dmem_vs_ref", dmem[i], ref_d[i]);

      // Both ports held: order follows the LS streak limit
      exp_seq = ""; streak = 0;
      for (int k = 0; k < 6; k++) begin
         if (streak == MAXS) begin exp_seq = {exp_seq, "I"}; streak = 0; end
         else begin exp_seq = {exp_seq, "L"}; streak++; end
      end
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = DATA + 32'h20;
      if_req = 1'b1; if_addr = TEXT + 32'h4;
      got = 0; cyc = 0; got_seq = "";
      while (got < 6 && cyc < 60) begin
         @(posedge clk); #1; cyc++;
         if (ls_ready) begin
            got_seq = {got_seq, "L"}; got++;
            chk("mix_ls_rdata", ls_rdata, ref_read(DATA + 32'h20));
         end
         if (if_ready) begin
            got_seq = {got_seq, "I"}; got++;
            chk("mix_if_rdata", if_rdata, 32'h2008_0005);
         end
         if (got == 6) begin ls_req = 1'b0; if_req = 1'b0; end
      end
      ls_req = 1'b0; if_req = 1'b0;
      chk("mix_count", got, 6);
      checks++;
      assert (got_seq == exp_seq) else begin
         errors++;
         $error("FAIL grant_order: observed %s expected %s", got_seq, exp_seq);
      end
      repeat (3) @(posedge clk);

      // Reset in the middle of a store
      old = ref_d[4];
      wd  = ~old;
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = DATA + 32'h10; ls_wdata = wd;
      @(posedge clk); #1;
      chk("midrst_enable_before", {31'b0, mem_enable}, 32'h1);
      reset = 1'b1;
      #1;
      chk("midrst_enable_after", {31'b0, mem_enable}, 32'h0);
      chk("midrst_addr", mem_addr, 32'h0);
      chk("midrst_wdata", mem_wdata, 32'h0);
      ls_req = 1'b0;
      seen = ls_ready;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         seen = seen | ls_ready;
      end
      chk("midrst_no_ready", seen, 0);
      chk("midrst_word_kept", dmem[4], old);
      ls_op(1'b0, DATA + 32'h10, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
